// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller definitions: field widths, command encodings and
// the packed command-queue entry.
package ddr3_pkg;

    localparam int DDR3_BANK_W = 3;
    localparam int ROW_W       = 14;
    localparam int COL_W       = 10;
    localparam int DATA_W      = 128;
    localparam int DM_W        = 8;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    typedef struct packed {
        logic                   sel;
        logic [DDR3_BANK_W-1:0] bank;
        logic [ROW_W-1:0]       row;
        logic [COL_W-1:0]       col;
        logic [DATA_W-1:0]      wrdata;
        logic [DM_W-1:0]        wrdm;
    } ddr3_cmd_t;

    localparam int CMD_W = $bits(ddr3_cmd_t);

endpackage

// File: rtl/ddr3_sync_fifo.sv
// Generic single-clock FIFO with a combinational head read. Pushes while full
// and pops while empty are ignored.
module ddr3_sync_fifo #(
    parameter int WIDTH = 164,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset so it can map onto RAM; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_cmd_queue.sv
// User command front-end: queues commands until read calibration is done,
// issues them in order toward rdcal, and forwards returned read data.
module ddr3_cmd_queue
    import ddr3_pkg::*;
#(
    parameter int p_FIFO_AW = 3,
    parameter int p_RD_MAX  = 8
) (
    input  logic          i_clk_div,
    input  logic          i_rst,
    input  logic          i_cmd_en,
    input  logic          i_cmd_sel,
    input  logic [2:0]    i3_bank,
    input  logic [13:0]   i14_row,
    input  logic [9:0]    i10_col,
    input  logic [127:0]  i128_wrdata,
    input  logic [7:0]    i8_wrdm,
    output logic          o_cmd_full,
    output logic          o_cmd_ovf,
    input  logic          i_rdcal_done,
    input  logic          i_phy_cmd_full,
    output logic          o_rdc_cmd_en,
    output logic          o_rdc_cmd_sel,
    output logic [2:0]    o3_rdc_bank,
    output logic [13:0]   o14_rdc_row,
    output logic [9:0]    o10_rdc_col,
    output logic [127:0]  o128_rdc_wrdata,
    output logic [7:0]    o8_rdc_wrdm,
    input  logic          i_phy_rddata_valid,
    input  logic [127:0]  in_phy_rddata,
    output logic          o_rddata_valid,
    output logic [127:0]  o128_rddata,
    output logic          o_rd_stray
);

    localparam logic [3:0] RD_MAX = 4'(p_RD_MAX);

    ddr3_cmd_t            push_cmd;
    ddr3_cmd_t            head;
    ddr3_cmd_t            rdc_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [p_FIFO_AW:0]   fifo_count_unused;
    logic                 pop;
    logic                 rd_pop;
    logic                 rd_ret;
    logic [3:0]           rd_out;

    assign push_cmd = '{sel: i_cmd_sel, bank: i3_bank, row: i14_row, col: i10_col,
                        wrdata: i128_wrdata, wrdm: i8_wrdm};

    ddr3_sync_fifo #(
        .WIDTH (CMD_W),
        .AW    (p_FIFO_AW)
    ) u_fifo (
        .clk   (i_clk_div),
        .rst   (i_rst),
        .push  (i_cmd_en),
        .pop   (pop),
        .din   (push_cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // Handshake: o_rdc_cmd_en is a one-cycle strobe with no ready; the PHY
    // holds off issue by raising i_phy_cmd_full, sampled in the pop cycle.
    assign pop    = !fifo_empty && i_rdcal_done && !i_phy_cmd_full &&
                    (head.sel == CMD_WR || rd_out < RD_MAX);
    assign rd_pop = pop && (head.sel == CMD_RD);
    assign rd_ret = i_phy_rddata_valid && i_rdcal_done && (rd_out != 4'd0);

    assign o_cmd_full      = fifo_full;
    assign o_rdc_cmd_sel   = rdc_q.sel;
    assign o3_rdc_bank     = rdc_q.bank;
    assign o14_rdc_row     = rdc_q.row;
    assign o10_rdc_col     = rdc_q.col;
    assign o128_rdc_wrdata = rdc_q.wrdata;
    assign o8_rdc_wrdm     = rdc_q.wrdm;

    always_ff @(posedge i_clk_div) begin
        if (i_rst) begin
            rdc_q          <= '0;
            o_rdc_cmd_en   <= 1'b0;
            o_cmd_ovf      <= 1'b0;
            rd_out         <= 4'd0;
            o_rddata_valid <= 1'b0;
            o128_rddata    <= '0;
            o_rd_stray     <= 1'b0;
        end else begin
            o_rdc_cmd_en <= pop;
            if (pop) rdc_q <= head;
            if (i_cmd_en && fifo_full) o_cmd_ovf <= 1'b1;
            case ({rd_pop, rd_ret})
                2'b10:   rd_out <= rd_out + 4'd1;
                2'b01:   rd_out <= rd_out - 4'd1;
                default: rd_out <= rd_out;
            endcase
            o_rddata_valid <= rd_ret;
            if (rd_ret) o128_rddata <= in_phy_rddata;
            // Calibration-time returns (done low) are expected and not flagged.
            if (i_phy_rddata_valid && i_rdcal_done && rd_out == 4'd0) o_rd_stray <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_queue.sv
// Directed plus randomized bench for ddr3_cmd_queue against a queue-based
// reference model of the command and read-return rules.
module tb_ddr3_cmd_queue;
    import ddr3_pkg::*;

    localparam int DEPTH  = 8;
    localparam int RD_MAX = 8;

    logic         clk;
    logic         rst;
    logic         cmd_en;
    logic         cmd_sel;
    logic [2:0]   bank;
    logic [13:0]  row;
    logic [9:0]   col;
    logic [127:0] wrdata;
    logic [7:0]   wrdm;
    logic         cmd_full;
    logic         cmd_ovf;
    logic         rdcal_done;
    logic         phy_cmd_full;
    logic         rdc_cmd_en;
    logic         rdc_cmd_sel;
    logic [2:0]   rdc_bank;
    logic [13:0]  rdc_row;
    logic [9:0]   rdc_col;
    logic [127:0] rdc_wrdata;
    logic [7:0]   rdc_wrdm;
    logic         phy_rdv;
    logic [127:0] phy_rddata;
    logic         rddata_valid;
    logic [127:0] rddata;
    logic         rd_stray;

    ddr3_cmd_queue dut (
        .i_clk_div          (clk),
        .i_rst              (rst),
        .i_cmd_en           (cmd_en),
        .i_cmd_sel          (cmd_sel),
        .i3_bank            (bank),
        .i14_row            (row),
        .i10_col            (col),
        .i128_wrdata        (wrdata),
        .i8_wrdm            (wrdm),
        .o_cmd_full         (cmd_full),
        .o_cmd_ovf          (cmd_ovf),
        .i_rdcal_done       (rdcal_done),
        .i_phy_cmd_full     (phy_cmd_full),
        .o_rdc_cmd_en       (rdc_cmd_en),
        .o_rdc_cmd_sel      (rdc_cmd_sel),
        .o3_rdc_bank        (rdc_bank),
        .o14_rdc_row        (rdc_row),
        .o10_rdc_col        (rdc_col),
        .o128_rdc_wrdata    (rdc_wrdata),
        .o8_rdc_wrdm        (rdc_wrdm),
        .i_phy_rddata_valid (phy_rdv),
        .in_phy_rddata      (phy_rddata),
        .o_rddata_valid     (rddata_valid),
        .o128_rddata        (rddata),
        .o_rd_stray         (rd_stray)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    ddr3_cmd_t    mq[$];
    int           m_rd_out;
    bit           m_ovf;
    bit           m_stray;
    bit           exp_en;
    ddr3_cmd_t    exp_cmd;
    bit           exp_rdv;
    logic [127:0] exp_rddata;
    bit           exp_full;

    int checks;
    int errors;
    int strobes;

    task automatic chk(input string tag, input logic [163:0] obs, input logic [163:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_cmd(input bit en, input bit sel);
        cmd_en  = en;
        cmd_sel = sel;
        bank    = 3'($urandom);
        row     = 14'($urandom);
        col     = 10'($urandom);
        wrdata  = {$urandom, $urandom, $urandom, $urandom};
        wrdm    = 8'($urandom);
    endtask

    // One clock: predict from the current inputs, clock, then compare.
    task automatic tick();
        ddr3_cmd_t cur;
        bit        full_now;
        bit        pop;
        bit        ret;
        ddr3_cmd_t obs;
        if (rst) begin
            mq.delete();
            m_rd_out   = 0;
            m_ovf      = 0;
            m_stray    = 0;
            exp_en     = 0;
            exp_cmd    = '0;
            exp_rdv    = 0;
            exp_rddata = '0;
        end else begin
            cur      = '{sel: cmd_sel, bank: bank, row: row, col: col, wrdata: wrdata, wrdm: wrdm};
            full_now = (mq.size() == DEPTH);
            pop      = (mq.size() != 0) && rdcal_done && !phy_cmd_full &&
                       (mq[0].sel == CMD_WR || m_rd_out < RD_MAX);
            ret      = phy_rdv && rdcal_done && (m_rd_out != 0);
            if (cmd_en && full_now) m_ovf = 1;
            if (phy_rdv && rdcal_done && m_rd_out == 0) m_stray = 1;
            exp_en = pop;
            if (pop) begin
                exp_cmd = mq.pop_front();
                if (exp_cmd.sel == CMD_RD) m_rd_out++;
            end
            exp_rdv = ret;
            if (ret) begin
                m_rd_out--;
                exp_rddata = phy_rddata;
            end
            if (cmd_en && !full_now) mq.push_back(cur);
        end
        exp_full = (mq.size() == DEPTH);
        @(posedge clk);
        #1;
        obs = '{sel: rdc_cmd_sel, bank: rdc_bank, row: rdc_row, col: rdc_col,
                wrdata: rdc_wrdata, wrdm: rdc_wrdm};
        chk("rdc_cmd_en", 164'(rdc_cmd_en), 164'(exp_en));
        chk("rdc_fields", obs, exp_cmd);
        chk("cmd_full", 164'(cmd_full), 164'(exp_full));
        chk("cmd_ovf", 164'(cmd_ovf), 164'(m_ovf));
        chk("rddata_valid", 164'(rddata_valid), 164'(exp_rdv));
        chk("rddata", 164'(rddata), 164'(exp_rddata));
        chk("rd_stray", 164'(rd_stray), 164'(m_stray));
        if (rdc_cmd_en) strobes++;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        strobes      = 0;
        rst          = 1'b1;
        rdcal_done   = 1'b1;
        phy_cmd_full = 1'b0;
        phy_rdv      = 1'b0;
        phy_rddata   = '0;
        rand_cmd(0, 0);

        // Reset, then a single write on an idle calibrated queue.
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        cmd_en = 1'b1; cmd_sel = CMD_WR; bank = 3'd2; row = 14'h0123; col = 10'h040;
        wrdata = {16{8'hA5}}; wrdm = 8'h00;
        strobes = 0;
        tick();
        cmd_en = 1'b0;
        repeat (4) tick();
        chk("t1_strobes", 164'(strobes), 164'(1));

        // Fill while calibrating: 9th push dropped, ovf sticky, then drain 8.
        rdcal_done = 1'b0;
        strobes = 0;
        for (int i = 0; i < 9; i++) begin
            rand_cmd(1, 1'($urandom_range(0, 1)));
            tick();
        end
        cmd_en = 1'b0;
        repeat (2) tick();
        chk("t2_no_issue", 164'(strobes), 164'(0));
        chk("t2_ovf", 164'(cmd_ovf), 164'(1));
        rdcal_done = 1'b1;
        repeat (10) tick();
        chk("t2_strobes", 164'(strobes), 164'(8));

        // Outstanding-read limit.
        rst = 1'b1; tick(); rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            rand_cmd(1, CMD_RD);
            tick();
        end
        cmd_en = 1'b0;
        repeat (5) tick();
        chk("t3_stall", 164'(strobes), 164'(8));
        phy_rdv = 1'b1; phy_rddata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        phy_rdv = 1'b0;
        repeat (3) tick();
        chk("t3_ninth", 164'(strobes), 164'(9));
        for (int i = 0; i < 9; i++) begin
            phy_rdv = 1'b1; phy_rddata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            phy_rdv = 1'b0;
            tick();
        end
        repeat (3) tick();
        chk("t3_all", 164'(strobes), 164'(10));

        // PHY back-pressure mid-stream.
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            rand_cmd(1, CMD_WR);
            phy_cmd_full = (i >= 2 && i < 7);
            tick();
        end
        cmd_en = 1'b0; phy_cmd_full = 1'b0;
        repeat (6) tick();
        chk("t4_strobes", 164'(strobes), 164'(8));

        // Calibration-time read data ignored; post-cal stray flagged.
        rdcal_done = 1'b0; phy_rdv = 1'b1; phy_rddata = {4{$urandom}};
        tick();
        phy_rdv = 1'b0;
        tick();
        chk("t5_cal_nostray", 164'(rd_stray), 164'(0));
        rdcal_done = 1'b1; phy_rdv = 1'b1;
        tick();
        phy_rdv = 1'b0;
        tick();
        chk("t5_stray", 164'(rd_stray), 164'(1));

        // Reset with reads outstanding and commands queued.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_cmd(1, CMD_RD);
            tick();
        end
        cmd_en = 1'b0;
        repeat (3) tick();
        rdcal_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_cmd(1, CMD_WR);
            tick();
        end
        cmd_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; rdcal_done = 1'b1;
        strobes = 0;
        for (int i = 0; i < 2; i++) begin
            rand_cmd(1, CMD_WR);
            tick();
        end
        cmd_en = 1'b0;
        repeat (4) tick();
        chk("t6_after_rst", 164'(strobes), 164'(2));

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst          = ($urandom_range(0, 199) == 0);
            rdcal_done   = ($urandom_range(0, 9) != 0);
            phy_cmd_full = ($urandom_range(0, 3) == 0);
            phy_rdv      = ($urandom_range(0, 9) < 3);
            phy_rddata   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_queue.md
Name: ddr3_cmd_queue

Overview:
User-side command front-end for the DDR3 x16 controller, sitting directly upstream of read calibration. Buffers user write/read commands in a small FIFO and holds them until read calibration reports done. It then issues them one per cycle onto the rdc command port, respecting PHY back-pressure. It tracks outstanding reads and forwards returned read data to the user, discarding calibration-time read traffic.

Parameters:
p_FIFO_AW, 3, log2 of command FIFO depth (8 entries)
p_RD_MAX, 8, max outstanding reads issued but not yet returned (1..15)

Ports:
i_clk_div  in  1  controller (divided) clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_cmd_en  in  1  user command strobe; accepted when o_cmd_full low
i_cmd_sel  in  1  0 = write, 1 = read
i3_bank  in  3  user bank
i14_row  in  14  user row
i10_col  in  10  user column
i128_wrdata  in  128  write burst data (ignored for reads)
i8_wrdm  in  8  write data mask
o_cmd_full  out  1  FIFO full; pushes ignored
o_cmd_ovf  out  1  sticky: i_cmd_en seen while full
i_rdcal_done  in  1  calibration complete; gates issue and read return
i_phy_cmd_full  in  1  PHY command back-pressure
o_rdc_cmd_en  out  1  one-cycle command strobe to rdcal
o_rdc_cmd_sel  out  1  issued command type
o3_rdc_bank, o14_rdc_row, o10_rdc_col  out  3/14/10  issued address
o128_rdc_wrdata  out  128  issued write data
o8_rdc_wrdm  out  8  issued mask
i_phy_rddata_valid  in  1  PHY read data strobe
in_phy_rddata  in  128  PHY read data
o_rddata_valid  out  1  user read data strobe
o128_rddata  out  128  user read data
o_rd_stray  out  1  sticky: read data returned with zero outstanding, post-cal

Behaviour:
- Reset: FIFO pointers and count = 0. Outstanding counter = 0. All outputs 0 (o_cmd_full = 0). Reset mid-operation flushes queued commands; reads already in flight are not tracked.
- FIFO entry = {sel, bank, row, col, wrdata, wrdm} = 164 bits. Depth 2^p_FIFO_AW. Count width p_FIFO_AW+1.
- Push: i_cmd_en && !o_cmd_full. o_cmd_full = (count == depth), registered.
- Push while full: dropped, o_cmd_ovf set, even if a pop occurs the same cycle. Cleared only by reset.
- Pop eligibility (cycle C): count != 0 && i_rdcal_done && !i_phy_cmd_full && (head.sel == 0 || rd_out < p_RD_MAX).
- On pop: o_rdc_cmd_en = 1 and the o_rdc_* fields are loaded from head in cycle C+1 (registered). Otherwise o_rdc_cmd_en = 0 and the fields hold their last value.
- Latency: command accepted in cycle A on an empty, eligible queue yields o_rdc_cmd_en high in cycle A+2. Sustained throughput is 1 command per cycle.
- Simultaneous push/pop with count between 1 and depth-1: count unchanged. Pointers wrap modulo depth.
- Ordering: strict FIFO. A read blocked on p_RD_MAX stalls writes queued behind it.
- rd_out counter:
  - +1 on a read pop.
  - -1 on i_phy_rddata_valid while i_rdcal_done && rd_out != 0.
  - Both in the same cycle: unchanged.
  - Never wraps; saturation is prevented by the pop gate.
- Read return: when i_phy_rddata_valid && i_rdcal_done && rd_out != 0, o_rddata_valid = 1 and o128_rddata = in_phy_rddata, one cycle later.
- i_phy_rddata_valid while !i_rdcal_done: calibration traffic. Ignored, no error.
- i_phy_rddata_valid while i_rdcal_done && rd_out == 0: data discarded, o_rd_stray set (sticky).
- i_rdcal_done falling (recalibration): issue halts next cycle. Queue contents and rd_out are retained.

Decomposition:
- Shared package ddr3_pkg:
  - width constants DDR3_BANK_W=3, ROW_W=14, COL_W=10, DATA_W=128, DM_W=8
  - command encodings CMD_WR=1'b0, CMD_RD=1'b1
  - packed command-entry typedef/width (164)
- One natural sub-module: ddr3_sync_fifo
  - generic single-clock FIFO, parameters width and AW
  - ports: push, pop, full, empty, count
  - ddr3_cmd_queue instantiates it with width 164

Test Plan:
- Reset, i_rdcal_done=1, push write (bank 2, row 0x0123, col 0x040, data 128'hA5..A5) in cycle 10 -> o_rdc_cmd_en high only in cycle 12 with identical fields, sel=0.
- i_rdcal_done=0, push 9 commands back-to-back -> o_cmd_full high after the 8th; 9th dropped; o_cmd_ovf=1; no o_rdc_cmd_en. Raise i_rdcal_done -> exactly 8 strobes in 8 consecutive cycles, in push order.
- Queue 10 reads, no read data returned -> exactly 8 issued, then stall. Return 1 rddata -> 9th issues; o_rddata_valid echoes the data one cycle after each return.
- i_phy_cmd_full held high for 5 cycles mid-stream -> no strobes in those cycles; issue resumes with no loss or duplication.
- i_phy_rddata_valid with i_rdcal_done=0 -> no o_rddata_valid, no error. Same with i_rdcal_done=1 and rd_out=0 -> o_rd_stray=1.
- Assert i_rst with 4 queued and 3 outstanding -> next cycle all outputs 0, count=0, rd_out=0; queue accepts pushes again.
